demux2_buf: RTL

DEMUX2_BUF -- requirements
Module: demux2_buf

---
 rtl/demux2_buf.sv | 109 ++++++++++
 1 files changed

// File: rtl/demux2_buf.sv
// Two-channel demultiplexer with a small FIFO per channel; s steers each accepted word.
// Optional pop counters (cnt0/cnt1) are added when DEMUX2_BUF_STATS_EN is defined.
module demux2_buf #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       y0_valid,
    output logic [3:0] y0_data,
    input  logic       y0_ready,
    output logic       y1_valid,
    output logic [3:0] y1_data,
    input  logic       y1_ready
`ifdef DEMUX2_BUF_STATS_EN
    ,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
`endif
);

    // DEPTH is restricted to 2 or 4, so pointers are 1 or 2 bits wide.
    localparam int AW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = AW + 1;

    logic [3:0]    mem    [2][DEPTH];
    logic [AW-1:0] wr_ptr [2];
    logic [AW-1:0] rd_ptr [2];
    logic [CW-1:0] count  [2];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_ready = {y1_ready, y0_ready};

    always_comb begin
        full     = '0;
        empty    = '0;
        push     = '0;
        pop      = '0;
        in_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            full[k]  = (count[k] == CW'(DEPTH));
            empty[k] = (count[k] == '0);
            pop[k]   = !empty[k] && out_ready[k];
        end
        // Readiness looks only at the selected channel's occupancy, never at downstream ready.
        in_ready = !full[s];
        push[0]  = in_valid && in_ready && !s;
        push[1]  = in_valid && in_ready && s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem[k][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= in_data;
                    wr_ptr[k]         <= bump(wr_ptr[k]);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= bump(rd_ptr[k]);
                end
                case ({push[k], pop[k]})
                    2'b10:   count[k] <= count[k] + 1'b1;
                    2'b01:   count[k] <= count[k] - 1'b1;
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    assign y0_valid = !empty[0];
    assign y1_valid = !empty[1];
    assign y0_data  = mem[0][rd_ptr[0]];
    assign y1_data  = mem[1][rd_ptr[1]];

`ifdef DEMUX2_BUF_STATS_EN
    // Pop counters wrap naturally at 8 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop[0]) cnt0 <= cnt0 + 8'd1;
            if (pop[1]) cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule
